// File: rtl/sram_bridge.sv
// Bridge from a narrow AVR-style control port (serial address load + command strobe)
// to an asynchronous SRAM, with fixed SETUP / STROBE / HOLD access timing.
module sram_bridge #(
  parameter int ADDR_W   = 21,
  parameter int DATA_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic              avr_clk,
  input  logic              avr_rst_n,
  input  logic              avr_si,
  input  logic              avr_shift,
  input  logic [2:0]        avr_ctrl,
  input  logic              avr_req,
  input  logic              avr_oe,
  inout  wire  [DATA_W-1:0] avr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic [2:0] CMD_LOAD  = 3'd1;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

  state_t            state;
  logic [ADDR_W-1:0] sreg;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_reg;
  logic [DATA_W-1:0] wr_reg;
  logic [3:0]        wait_cnt;
  logic              wr_op;
  logic              inc_op;

  logic is_rw;
  logic is_wr;
  logic is_inc;

  always_comb begin
    is_rw  = (avr_ctrl >= 3'd2) && (avr_ctrl <= 3'd5);
    is_wr  = (avr_ctrl == 3'd3) || (avr_ctrl == 3'd5);
    is_inc = (avr_ctrl == 3'd4) || (avr_ctrl == 3'd5);
  end

  assign sram_addr = addr;
  // wr_op is only set between acceptance and the return to IDLE, so it doubles as the write-bus enable.
  assign sram_data = wr_op ? wr_reg : {DATA_W{1'bz}};
  assign avr_data  = (avr_oe && !wr_op && avr_rst_n) ? rd_reg : {DATA_W{1'bz}};

  always_ff @(posedge avr_clk) begin
    if (!avr_rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      addr      <= '0;
      rd_reg    <= '0;
      wr_reg    <= '0;
      wait_cnt  <= '0;
      wr_op     <= 1'b0;
      inc_op    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      if (avr_shift)
        sreg <= {sreg[ADDR_W-2:0], avr_si};
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (avr_req) begin
            if (avr_ctrl == CMD_LOAD) begin
              addr <= sreg;
              done <= 1'b1;
            end else if (is_rw) begin
              state     <= SETUP;
              busy      <= 1'b1;
              sram_ce_n <= 1'b0;
              wr_op     <= is_wr;
              inc_op    <= is_inc;
              if (is_wr)
                wr_reg <= avr_data;
            end
          end
        end
        SETUP: begin
          state    <= STROBE;
          wait_cnt <= '0;
          if (wr_op)
            sram_we_n <= 1'b0;
          else
            sram_oe_n <= 1'b0;
        end
        STROBE: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= HOLD;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!wr_op)
              rd_reg <= sram_data;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          busy      <= 1'b0;
          sram_ce_n <= 1'b1;
          done      <= 1'b1;
          wr_op     <= 1'b0;
          if (inc_op)
            addr <= addr + ADDR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
